// File: rtl/fcp_link_pkg.sv
// rtl/fcp_link_pkg.sv - shared widths, FCP beat field offsets and delay-entry type for the FCP link
package fcp_link_pkg;

    localparam int FCP_AXIS_WIDTH = 128;
    localparam int FCP_TS_WIDTH   = 16;

    // FCP beat layout; the delay channel never decodes these, they exist for checkers and stimulus
    localparam int FCP_VC_LSB   = 0;
    localparam int FCP_VC_W     = 8;
    localparam int FCP_FCCL_LSB = 8;
    localparam int FCP_FCCL_W   = 32;
    localparam int FCP_QLEN_LSB = 40;
    localparam int FCP_QLEN_W   = 32;
    localparam int FCP_FCCR_LSB = 72;
    localparam int FCP_FCCR_W   = 32;

    typedef struct packed {
        logic [FCP_AXIS_WIDTH-1:0] data;
        logic [FCP_TS_WIDTH-1:0]   rel_ts;
    } fcp_delay_entry_t;

endpackage

// File: rtl/fcp_link_delay_channel_if.sv
// rtl/fcp_link_delay_channel_if.sv - AXIS-style FCP beat stream interface
interface fcp_link_delay_channel_if
    import fcp_link_pkg::*;
#(
    parameter int WIDTH = FCP_AXIS_WIDTH
);
    logic [WIDTH-1:0] tdata;
    logic             tvalid;
    logic             tready;

    modport master (output tdata, output tvalid, input tready);
    modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/fcp_delay_fifo.sv
// rtl/fcp_delay_fifo.sv - dual-port in-flight storage with registered pointers and occupancy
module fcp_delay_fifo
    import fcp_link_pkg::*;
#(
    parameter int DATA_WIDTH = FCP_AXIS_WIDTH + FCP_TS_WIDTH,
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] head_data,
    output logic [ADDR_WIDTH:0]   occupancy,
    output logic                  full,
    output logic                  empty
);
    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
    logic [ADDR_WIDTH:0]   wr_ptr;
    logic [ADDR_WIDTH:0]   rd_ptr;
    logic                  do_push;
    logic                  do_pop;

    assign do_push   = push && !full;
    assign do_pop    = pop && !empty;
    assign occupancy = wr_ptr - rd_ptr;
    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]) &&
                       (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]);
    assign head_data = mem[rd_ptr[ADDR_WIDTH-1:0]];

    // Storage write port; contents need no reset since pointers gate visibility
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[ADDR_WIDTH-1:0]] <= push_data;
        end
    end

    // Pointer update; clear empties the FIFO regardless of push/pop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (ADDR_WIDTH+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (ADDR_WIDTH+1)'(1);
        end
    end

endmodule

// File: rtl/fcp_link_delay_channel.sv
// rtl/fcp_link_delay_channel.sv - programmable-delay FCP return path with drop and forward statistics
module fcp_link_delay_channel
    import fcp_link_pkg::*;
#(
    parameter int AXIS_WIDTH      = FCP_AXIS_WIDTH,
    parameter int FIFO_ADDR_WIDTH = 6,
    parameter int TS_WIDTH        = FCP_TS_WIDTH,
    parameter bit LOSSY_MODE      = 1'b1,
    parameter int STAT_WIDTH      = 32
) (
    input  logic                           clk,
    input  logic                           rst_n,
    fcp_link_delay_channel_if.slave        s_axis_fcp,
    fcp_link_delay_channel_if.master       m_axis_fcp,
    input  logic [TS_WIDTH-2:0]            cfg_delay,
    input  logic                           cfg_flush,
    output logic [STAT_WIDTH-1:0]          stat_fwd_count,
    output logic [STAT_WIDTH-1:0]          stat_drop_count,
    output logic [FIFO_ADDR_WIDTH:0]       stat_occupancy
);
    localparam int ENTRY_W    = AXIS_WIDTH + TS_WIDTH;
    localparam int DROP_INC_W = FIFO_ADDR_WIDTH + 2;
    localparam logic [TS_WIDTH-1:0] TS_HALF = {1'b1, {(TS_WIDTH-1){1'b0}}};

    logic [TS_WIDTH-1:0]     ts;
    logic [TS_WIDTH-1:0]     age;
    logic [TS_WIDTH-1:0]     head_rel_ts;
    logic [AXIS_WIDTH-1:0]   head_tdata;
    logic [ENTRY_W-1:0]      head_entry;
    logic [ENTRY_W-1:0]      push_entry;
    logic [FIFO_ADDR_WIDTH:0] occupancy;
    logic                    full;
    logic                    empty;
    logic                    s_hs;
    logic                    push;
    logic                    in_drop;
    logic                    eligible;
    logic                    load;
    logic                    m_hs;
    logic [AXIS_WIDTH-1:0]   out_tdata;
    logic                    out_tvalid;
    logic [DROP_INC_W-1:0]   drop_inc;
    logic [STAT_WIDTH:0]     drop_sum;

    // Lossy links never stall the source; lossless ones stall exactly when storage is full
    assign s_axis_fcp.tready = LOSSY_MODE ? 1'b1 : (rst_n && !full);

    assign s_hs       = s_axis_fcp.tvalid && s_axis_fcp.tready;
    assign push       = s_hs && !full && !cfg_flush;
    assign in_drop    = s_hs && (full || cfg_flush);
    assign push_entry = {s_axis_fcp.tdata, ts + {1'b0, cfg_delay}};

    assign head_tdata  = head_entry[ENTRY_W-1:TS_WIDTH];
    assign head_rel_ts = head_entry[TS_WIDTH-1:0];
    // Wrap-safe "now >= rel_ts": the difference is non-negative when its MSB is clear
    assign age      = ts - head_rel_ts;
    assign eligible = !empty && (age < TS_HALF);

    assign m_hs = out_tvalid && m_axis_fcp.tready;
    assign load = eligible && (!out_tvalid || m_axis_fcp.tready) && !cfg_flush;

    assign m_axis_fcp.tdata  = out_tdata;
    assign m_axis_fcp.tvalid = out_tvalid;
    assign stat_occupancy    = occupancy;

    fcp_delay_fifo #(
        .DATA_WIDTH (ENTRY_W),
        .ADDR_WIDTH (FIFO_ADDR_WIDTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (cfg_flush),
        .push      (push),
        .push_data (push_entry),
        .pop       (load),
        .head_data (head_entry),
        .occupancy (occupancy),
        .full      (full),
        .empty     (empty)
    );

    // Free-running timestamp, wraps naturally
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ts <= '0;
        else        ts <= ts + TS_WIDTH'(1);
    end

    // Output stage: flush invalidates, otherwise load on release or empty out after a handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_tvalid <= 1'b0;
            out_tdata  <= '0;
        end else if (cfg_flush) begin
            out_tvalid <= 1'b0;
        end else if (load) begin
            out_tvalid <= 1'b1;
            out_tdata  <= head_tdata;
        end else if (m_axis_fcp.tready) begin
            out_tvalid <= 1'b0;
        end
    end

    // Beats lost this cycle: overflow/flush-time arrivals, plus stored and unconsumed staged beats on flush
    always_comb begin
        drop_inc = '0;
        if (cfg_flush) begin
            drop_inc = DROP_INC_W'(occupancy) + DROP_INC_W'(out_tvalid && !m_axis_fcp.tready);
        end
        drop_inc = drop_inc + DROP_INC_W'(in_drop);
    end

    assign drop_sum = {1'b0, stat_drop_count} + (STAT_WIDTH+1)'(drop_inc);

    // Saturating statistics
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_fwd_count  <= '0;
            stat_drop_count <= '0;
        end else begin
            if (m_hs && !(&stat_fwd_count)) begin
                stat_fwd_count <= stat_fwd_count + STAT_WIDTH'(1);
            end
            stat_drop_count <= drop_sum[STAT_WIDTH] ? '1 : drop_sum[STAT_WIDTH-1:0];
        end
    end

endmodule

// File: tb/tb_fcp_link_delay_channel.sv
// tb/tb_fcp_link_delay_channel.sv - directed self-checking bench for fcp_link_delay_channel
module tb_fcp_link_delay_channel;
    import fcp_link_pkg::*;

    logic        clk;
    logic        rst_n;
    logic [14:0] cfg_delay;
    logic        cfg_flush;
    logic [31:0] fwd_a, drop_a, fwd_b, drop_b;
    logic [6:0]  occ_a, occ_b;
    logic [15:0] tcount;
    int          n_checks;
    int          n_fail;

    fcp_link_delay_channel_if sa();
    fcp_link_delay_channel_if ma();
    fcp_link_delay_channel_if sb();
    fcp_link_delay_channel_if mb();

    fcp_link_delay_channel #(.LOSSY_MODE(1'b1)) dut_lossy (
        .clk (clk), .rst_n (rst_n), .s_axis_fcp (sa), .m_axis_fcp (ma),
        .cfg_delay (cfg_delay), .cfg_flush (cfg_flush),
        .stat_fwd_count (fwd_a), .stat_drop_count (drop_a), .stat_occupancy (occ_a)
    );

    fcp_link_delay_channel #(.LOSSY_MODE(1'b0)) dut_lossless (
        .clk (clk), .rst_n (rst_n), .s_axis_fcp (sb), .m_axis_fcp (mb),
        .cfg_delay (cfg_delay), .cfg_flush (cfg_flush),
        .stat_fwd_count (fwd_b), .stat_drop_count (drop_b), .stat_occupancy (occ_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle count since reset release equals the channel timestamp value
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) tcount <= '0;
        else        tcount <= tcount + 16'd1;
    end

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_checks++; if (ma.tvalid !== 1'b0) begin n_fail++; $display("FAIL reset_m_tvalid: got %0b expected 0", ma.tvalid); end
        n_checks++; if (ma.tdata !== '0) begin n_fail++; $display("FAIL reset_m_tdata: got %0h expected 0", ma.tdata); end
        n_checks++; if (fwd_a !== 0 || drop_a !== 0) begin n_fail++; $display("FAIL reset_stats: got fwd %0d drop %0d expected 0 0", fwd_a, drop_a); end
        n_checks++; if (sa.tready !== 1'b1) begin n_fail++; $display("FAIL reset_lossy_tready: got %0b expected 1", sa.tready); end
        n_checks++; if (sb.tready !== 1'b0) begin n_fail++; $display("FAIL reset_lossless_tready: got %0b expected 0", sb.tready); end
        sa.tvalid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++; if (sb.tready !== 1'b1) begin n_fail++; $display("FAIL post_reset_lossless_tready: got %0b expected 1", sb.tready); end
        n_checks++; if (occ_a !== 0 || drop_a !== 0) begin n_fail++; $display("FAIL reset_beats_ignored: got occ %0d drop %0d expected 0 0", occ_a, drop_a); end
    endtask

    task automatic test_single_delay();
        int lat;
        logic [127:0] got;
        lat = -1;
        got = '0;
        cfg_delay = 15'd10;
        ma.tready = 1'b1;
        sa.tdata = '0;
        sa.tdata[FCP_VC_LSB +: FCP_VC_W] = 8'hA5;
        sa.tvalid = 1'b1;
        for (int j = 1; j <= 40; j++) begin
            @(negedge clk);
            if (j == 1) sa.tvalid = 1'b0;
            if (ma.tvalid && lat < 0) begin lat = j; got = ma.tdata; end
        end
        n_checks++; if (lat != 11) begin n_fail++; $display("FAIL d10_latency: got %0d expected 11", lat); end
        n_checks++; if (got !== 128'hA5) begin n_fail++; $display("FAIL d10_tdata: got %0h expected a5", got); end
        n_checks++; if (fwd_a !== 32'd1) begin n_fail++; $display("FAIL d10_fwd: got %0d expected 1", fwd_a); end
    endtask

    task automatic test_back_to_back();
        int first, cnt, bad;
        logic [127:0] exp;
        first = -1; cnt = 0; bad = 0;
        cfg_delay = 15'd0;
        for (int j = 0; j < 20; j++) begin
            if (ma.tvalid) begin
                if (first < 0) first = j;
                exp = 128'h100 + 128'(cnt);
                if (ma.tdata !== exp || j != first + cnt) bad++;
                cnt++;
            end
            if (j < 8) begin sa.tdata = 128'h100 + 128'(j); sa.tvalid = 1'b1; end
            else sa.tvalid = 1'b0;
            @(negedge clk);
        end
        n_checks++; if (first != 2) begin n_fail++; $display("FAIL b2b_first_latency: got %0d expected 2", first); end
        n_checks++; if (cnt != 8 || bad != 0) begin n_fail++; $display("FAIL b2b_stream: got %0d beats %0d bad expected 8 beats 0 bad", cnt, bad); end
        n_checks++; if (occ_a !== 0 || fwd_a !== 32'd9) begin n_fail++; $display("FAIL b2b_occ_fwd: got occ %0d fwd %0d expected 0 9", occ_a, fwd_a); end
    endtask

    task automatic test_lossy_overflow();
        int low, cnt, bad;
        logic [127:0] exp;
        low = 0; cnt = 0; bad = 0;
        cfg_delay = 15'd1000;
        for (int j = 0; j < 70; j++) begin
            sa.tdata = 128'h200 + 128'(j);
            sa.tvalid = 1'b1;
            if (sa.tready !== 1'b1) low++;
            @(negedge clk);
        end
        sa.tvalid = 1'b0;
        n_checks++; if (low != 0) begin n_fail++; $display("FAIL lossy_tready_low: got %0d low cycles expected 0", low); end
        n_checks++; if (occ_a !== 7'd64) begin n_fail++; $display("FAIL lossy_occupancy: got %0d expected 64", occ_a); end
        n_checks++; if (drop_a !== 32'd6) begin n_fail++; $display("FAIL lossy_drops: got %0d expected 6", drop_a); end
        for (int j = 0; j < 1100; j++) begin
            if (ma.tvalid) begin
                exp = 128'h200 + 128'(cnt);
                if (ma.tdata !== exp) bad++;
                cnt++;
            end
            @(negedge clk);
        end
        n_checks++; if (cnt != 64 || bad != 0) begin n_fail++; $display("FAIL lossy_drain: got %0d beats %0d bad expected 64 beats 0 bad", cnt, bad); end
        n_checks++; if (fwd_a !== 32'd73 || occ_a !== 0) begin n_fail++; $display("FAIL lossy_fwd_occ: got fwd %0d occ %0d expected 73 0", fwd_a, occ_a); end
    endtask

    task automatic test_lossless_backpressure();
        int i, stall, cnt, bad;
        logic [127:0] exp;
        i = 0; stall = -1; cnt = 0; bad = 0;
        cfg_delay = 15'd1000;
        mb.tready = 1'b0;
        for (int j = 0; j < 2200; j++) begin
            if (j == 100) mb.tready = 1'b1;
            if (mb.tvalid && mb.tready) begin
                exp = 128'h300 + 128'(cnt);
                if (mb.tdata !== exp) bad++;
                cnt++;
            end
            if (i < 70) begin
                sb.tdata = 128'h300 + 128'(i);
                sb.tvalid = 1'b1;
                if (sb.tready) i++;
                else if (stall < 0) stall = i;
            end else begin
                sb.tvalid = 1'b0;
            end
            @(negedge clk);
        end
        sb.tvalid = 1'b0;
        n_checks++; if (stall != 64) begin n_fail++; $display("FAIL lossless_first_stall: got %0d accepts expected 64", stall); end
        n_checks++; if (i != 70) begin n_fail++; $display("FAIL lossless_accepts: got %0d expected 70", i); end
        n_checks++; if (cnt != 70 || bad != 0) begin n_fail++; $display("FAIL lossless_delivery: got %0d beats %0d bad expected 70 beats 0 bad", cnt, bad); end
        n_checks++; if (drop_b !== 0 || fwd_b !== 32'd70) begin n_fail++; $display("FAIL lossless_stats: got drop %0d fwd %0d expected 0 70", drop_b, fwd_b); end
    endtask

    task automatic test_hol_blocking();
        int seen, ja, jb;
        logic [127:0] da, db;
        seen = 0; ja = -1; jb = -1; da = '0; db = '0;
        ma.tready = 1'b1;
        for (int j = 0; j < 40; j++) begin
            if (ma.tvalid) begin
                if (seen == 0) begin ja = j; da = ma.tdata; end
                else if (seen == 1) begin jb = j; db = ma.tdata; end
                seen++;
            end
            if (j == 0) begin cfg_delay = 15'd20; sa.tdata = 128'hAA; sa.tvalid = 1'b1; end
            else if (j == 1) begin cfg_delay = 15'd2; sa.tdata = 128'hBB; end
            else sa.tvalid = 1'b0;
            @(negedge clk);
        end
        n_checks++; if (ja != 21 || da !== 128'hAA) begin n_fail++; $display("FAIL hol_beat_a: got cycle %0d data %0h expected 21 aa", ja, da); end
        n_checks++; if (jb != 22 || db !== 128'hBB) begin n_fail++; $display("FAIL hol_beat_b: got cycle %0d data %0h expected 22 bb", jb, db); end
        n_checks++; if (seen != 2 || fwd_a !== 32'd75) begin n_fail++; $display("FAIL hol_count: got %0d beats fwd %0d expected 2 75", seen, fwd_a); end
    endtask

    task automatic test_ts_wrap_and_flush();
        int lat;
        logic [127:0] got;
        lat = -1; got = '0;
        for (int j = 0; j < 70000 && tcount != 16'hFFF8; j++) @(negedge clk);
        n_checks++; if (tcount !== 16'hFFF8) begin n_fail++; $display("FAIL wrap_wait_timeout: got ts %0h expected fff8", tcount); end
        cfg_delay = 15'd16;
        ma.tready = 1'b1;
        sa.tdata = 128'hC3;
        sa.tvalid = 1'b1;
        for (int j = 1; j <= 40; j++) begin
            @(negedge clk);
            if (j == 1) sa.tvalid = 1'b0;
            if (ma.tvalid && lat < 0) begin lat = j; got = ma.tdata; end
        end
        n_checks++; if (lat != 17 || got !== 128'hC3) begin n_fail++; $display("FAIL wrap_latency: got %0d data %0h expected 17 c3", lat, got); end

        ma.tready = 1'b0;
        cfg_delay = 15'd3;
        for (int j = 0; j < 6; j++) begin
            sa.tdata = 128'h400 + 128'(j);
            sa.tvalid = 1'b1;
            @(negedge clk);
        end
        sa.tvalid = 1'b0;
        repeat (8) @(negedge clk);
        n_checks++; if (occ_a !== 7'd5 || ma.tvalid !== 1'b1) begin n_fail++; $display("FAIL preflush_state: got occ %0d tvalid %0b expected 5 1", occ_a, ma.tvalid); end
        n_checks++; if (ma.tdata !== 128'h400 || fwd_a !== 32'd76) begin n_fail++; $display("FAIL preflush_hold: got data %0h fwd %0d expected 400 76", ma.tdata, fwd_a); end
        cfg_flush = 1'b1;
        @(negedge clk);
        cfg_flush = 1'b0;
        n_checks++; if (ma.tvalid !== 1'b0 || occ_a !== 0) begin n_fail++; $display("FAIL flush_clear: got tvalid %0b occ %0d expected 0 0", ma.tvalid, occ_a); end
        n_checks++; if (drop_a !== 32'd12) begin n_fail++; $display("FAIL flush_drops: got %0d expected 12", drop_a); end

        ma.tready = 1'b1;
        cfg_flush = 1'b1;
        sa.tdata = 128'h4FF;
        sa.tvalid = 1'b1;
        @(negedge clk);
        cfg_flush = 1'b0;
        sa.tvalid = 1'b0;
        n_checks++; if (drop_a !== 32'd13 || occ_a !== 0) begin n_fail++; $display("FAIL flush_inbeat_drop: got drop %0d occ %0d expected 13 0", drop_a, occ_a); end
        repeat (10) @(negedge clk);
        n_checks++; if (ma.tvalid !== 1'b0 || fwd_a !== 32'd76) begin n_fail++; $display("FAIL flush_nothing_emerges: got tvalid %0b fwd %0d expected 0 76", ma.tvalid, fwd_a); end
    endtask

    task automatic test_async_reset();
        int found;
        found = 0;
        ma.tready = 1'b1;
        cfg_delay = 15'd5;
        for (int j = 0; j < 4; j++) begin
            sa.tdata = 128'h500 + 128'(j);
            sa.tvalid = 1'b1;
            @(negedge clk);
        end
        sa.tvalid = 1'b0;
        for (int j = 0; j < 20 && !found; j++) begin
            if (ma.tvalid) found = 1;
            else @(negedge clk);
        end
        n_checks++; if (found != 1) begin n_fail++; $display("FAIL midstream_output_timeout: got %0d expected 1", found); end
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (ma.tvalid !== 1'b0 || ma.tdata !== '0) begin n_fail++; $display("FAIL async_reset_output: got tvalid %0b data %0h expected 0 0", ma.tvalid, ma.tdata); end
        n_checks++; if (fwd_a !== 0 || drop_a !== 0 || occ_a !== 0) begin n_fail++; $display("FAIL async_reset_stats: got fwd %0d drop %0d occ %0d expected 0 0 0", fwd_a, drop_a, occ_a); end
        n_checks++; if (sb.tready !== 1'b0 || fwd_b !== 0) begin n_fail++; $display("FAIL async_reset_lossless: got tready %0b fwd %0d expected 0 0", sb.tready, fwd_b); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        n_checks++; if (ma.tvalid !== 1'b0 || fwd_a !== 0) begin n_fail++; $display("FAIL reset_discards_inflight: got tvalid %0b fwd %0d expected 0 0", ma.tvalid, fwd_a); end
    endtask

    initial begin
        n_checks = 0;
        n_fail = 0;
        rst_n = 1'b0;
        cfg_delay = '0;
        cfg_flush = 1'b0;
        sa.tdata = 128'h1234;
        sa.tvalid = 1'b1;
        ma.tready = 1'b1;
        sb.tdata = '0;
        sb.tvalid = 1'b0;
        mb.tready = 1'b1;
        test_reset();
        test_single_delay();
        test_back_to_back();
        test_lossy_overflow();
        test_lossless_backpressure();
        test_hol_blocking();
        test_ts_wrap_and_flush();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fcp_link_delay_channel.md
Name: fcp_link_delay_channel

Overview:
Emulates the physical FCP return path between fcp_source_adapter (downstream switch side) and fcp_sink_adapter (injector side) on the 128-bit AXIS FCP link.
- Every accepted FCP beat is held for a programmable number of cycles, then released in order, so flow-control loop stability can be studied under realistic round-trip delay.
- Provides lossy or lossless backpressure behaviour, plus forward, drop and occupancy statistics.

Parameters:
AXIS_WIDTH, 128, FCP beat width (opaque payload; never decoded).
FIFO_ADDR_WIDTH, 6, in-flight storage depth = 2**FIFO_ADDR_WIDTH beats.
TS_WIDTH, 16, free-running timestamp width; cfg_delay must be < 2**(TS_WIDTH-1).
LOSSY_MODE, 1, 1 = s_axis_fcp_tready tied high and overflow drops; 0 = backpressure when full.
STAT_WIDTH, 32, statistics counter width.

Ports:
clk  in  1  sole clock.
rst_n  in  1  asynchronous active-low reset.
s_axis_fcp_tdata  in  AXIS_WIDTH  FCP beat from the source adapter.
s_axis_fcp_tvalid  in  1  beat valid.
s_axis_fcp_tready  out  1  beat accepted when high with tvalid.
m_axis_fcp_tdata  out  AXIS_WIDTH  delayed beat to the sink adapter.
m_axis_fcp_tvalid  out  1  delayed beat valid.
m_axis_fcp_tready  in  1  sink ready.
cfg_delay  in  TS_WIDTH-1  link delay D in cycles; sampled per beat at acceptance.
cfg_flush  in  1  synchronous discard of all stored and output-staged beats.
stat_fwd_count  out  STAT_WIDTH  beats delivered on m_axis.
stat_drop_count  out  STAT_WIDTH  beats dropped (overflow plus flush).
stat_occupancy  out  FIFO_ADDR_WIDTH+1  beats stored, excluding the output register.

Behaviour:
Reset (asynchronous, rst_n low):
- FIFO pointers, timestamp, output register and all statistics clear.
- m_axis_fcp_tvalid = 0 and m_axis_fcp_tdata = 0.
- s_axis_fcp_tready = LOSSY_MODE ? 1 : 0 during reset. In lossy mode, beats arriving during reset are not counted.
- Reset asserted mid-operation discards in-flight beats without counting them.

Timestamp:
- ts increments every cycle and wraps modulo 2**TS_WIDTH.

Accept:
- The handshake in cycle T writes {tdata, rel_ts = ts(T) + cfg_delay(T)} to the FIFO tail.
- The entry becomes visible at the FIFO head from cycle T+1.

Eligibility:
- The head is eligible when the MSB of (ts - rel_ts) is 0. This is a wrap-safe signed comparison.

Release:
- The output register loads the head at the clock edge ending any cycle in which the head is eligible and the output register is empty or being drained (m_tvalid && m_tready).
- Latency from accept to m_axis_fcp_tvalid rising is max(2, D+1) cycles.
- Back-to-back eligible beats sustain 1 beat per cycle.

Ordering:
- Strict FIFO order. If cfg_delay decreases, a later beat waits behind the head (head-of-line blocking).
- Release never happens before the beat's own rel_ts.

Output register:
- m_tdata and m_tvalid hold stable while m_tvalid && !m_tready (AXIS rule).

Full condition: occupancy == 2**FIFO_ADDR_WIDTH.
- Lossless mode: tready = !full, registered-free (combinational from pointers). No pass-through of simultaneous push and pop when full.
- Lossy mode: a beat offered while full is discarded and stat_drop_count increments, even if a pop occurs in the same cycle.

Empty condition:
- Nothing is eligible; the output register only drains.

Flush (cfg_flush high for one cycle):
- Pointers reset; the output register is invalidated next edge.
- stat_drop_count += occupancy + (m_tvalid ? 1 : 0).
- A beat offered in the same cycle is dropped and counted.
- An output handshake in the same cycle counts as forwarded, not dropped.

Statistics:
- stat_fwd_count increments on each m_axis handshake.
- Counters saturate at all-ones and never wrap.

Decomposition:
Shared package fcp_link_pkg:
- FCP_AXIS_WIDTH = 128.
- FCP beat field offsets (vc, fccl, qlen, fccr) for bench decode.
- Delay-entry struct {data, rel_ts}.

Sub-module fcp_delay_fifo:
- Simple dual-port storage, registered pointers, occupancy, full/empty.
- Head read is combinational from registered storage.
- The channel top owns the timestamp, eligibility, output register, mode logic and statistics.

Test Plan:
1. D=10, one beat 0xA5 accepted at cycle 100, m_tready=1 -> m_tvalid rises at cycle 111 with tdata 0xA5; stat_fwd_count=1.
2. D=0, 8 back-to-back beats -> first output at accept+2, then 8 consecutive output cycles, order preserved, occupancy returns to 0.
3. LOSSY_MODE=1, depth 64, D=1000, 70 beats back-to-back -> 64 stored, stat_drop_count=6, tready never low; after drain, exactly beats 0..63 are delivered.
4. LOSSY_MODE=0, same stimulus -> tready low after 64 accepts and no drops; all 70 beats are delivered in order once m_tready=1.
5. D=20 for beat A, then D=2 for beat B one cycle later -> B emerges in the cycle after A (head-of-line blocking), never before A.
6. Timestamp wrap: ts preloaded near 0xFFF8 via run time, D=16 -> release 17 cycles after accept. Then cfg_flush with 5 stored and 1 staged -> stat_drop_count += 6 and m_tvalid=0 next cycle. Then rst_n low mid-stream -> all outputs zero asynchronously.
